prog_image_loader: RTL
======================

Name: prog_image_loader

Overview:
- Synthesizable successor to the bench-side program-image reader.
- Consumes a valid/ready command stream: set-address, data-byte, end.
- Packs bytes into DATA_W-wide words with byte enables and writes them through a req/gnt memory write port.
- Sits between the debug/host loader channel and instruction/data SRAM; loads images without backdoor access.

Parameters:
- ADDR_W, 32, byte-address width; cur_addr wraps modulo 2^ADDR_W.
- DATA_W, 32, memory word width; must be 8*2^k, range 8..128; elaboration error otherwise.
- CNT_W, 24, width of the accepted-byte counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; leaves DONE, clears cur_addr, byte_cnt and err
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid & in_ready
- in_op  in  2  0=SET_ADDR, 1=DATA, 2=END, 3=reserved
- in_data  in  ADDR_W  address for SET_ADDR; byte in [7:0] for DATA
- mem_req  out  1  write request
- mem_gnt  in  1  write accepted this cycle
- mem_addr  out  ADDR_W  word-aligned byte address, low log2(DATA_W/8) bits zero
- mem_wdata  out  DATA_W  packed write data
- mem_be  out  DATA_W/8  byte enables
- done  out  1  image complete
- byte_cnt  out  CNT_W  DATA bytes accepted, saturating
- err  out  1  sticky; set by reserved op

Behaviour:
- Reset values: state=RUN, in_ready=1, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, byte_cnt=0, err=0, cur_addr=0, buffer empty.
- Reset mid-transfer abandons the buffer and any pending request.
- Internal state: cur_addr, buf_word, buf_data, buf_be. buf_valid is true when buf_be is nonzero.
- States: RUN, FLUSH, DONE.
- in_ready=1 only in RUN. mem_req=1 only in FLUSH.
- RUN, DATA:
  - Lane = cur_addr low bits; write the byte to that lane, set its be bit, buf_word = word(cur_addr), cur_addr++, byte_cnt++.
  - Rewriting the same lane overwrites it (last write wins).
  - If lane = BYTES-1, go to FLUSH next cycle: mem_req is high in the cycle after acceptance.
- RUN, SET_ADDR:
  - cur_addr = in_data.
  - If buf_valid and word(in_data) != buf_word, go to FLUSH. Otherwise stay in RUN with no write.
- RUN, END:
  - If buf_valid, go to FLUSH with end_pend=1. Otherwise go to DONE.
- RUN, op 3: accepted, err=1, no other effect.
- FLUSH:
  - mem_addr/mem_wdata/mem_be hold stable while mem_req=1 and gnt=0.
  - On mem_gnt: clear buf_be and buf_data. Go to DONE if end_pend, else RUN.
  - A gnt in the same cycle req rises completes the write (1-cycle flush minimum).
- DONE: done=1, in_ready=0. start goes to RUN and clears done, cur_addr, byte_cnt and err. start in RUN/FLUSH is ignored.
- Wrap: cur_addr 2^ADDR_W-1 incremented becomes 0, no flag. A last-lane byte at the top address flushes normally.
- byte_cnt saturates at 2^CNT_W-1.
- mem_gnt outside FLUSH is ignored.

Optional Feature:
- Macro PROG_IMAGE_LOADER_CHECKSUM_EN.
- When defined:
  - Extra port csum out 32: sum modulo 2^32 of every accepted DATA byte, zero-extended.
  - Reset and start clear it.
  - Updates the cycle after acceptance, same as byte_cnt.
- When undefined: port and logic are absent.

Decomposition:
- prog_image_pkg (shared) adds:
  - enum pil_op_e {PIL_SET_ADDR, PIL_DATA, PIL_END, PIL_RSVD}
  - enum pil_state_e {PIL_RUN, PIL_FLUSH, PIL_DONE}
  - function lane_of(addr, bytes)
- One sub-module, prog_image_pack: byte-lane buffer (buf_data/buf_be/buf_word, write-lane, clear). The FSM, counters and handshake stay in the top.

Test Plan (DATA_W=32 unless noted):
- SET_ADDR 0x100, DATA 11,22,33,44: one write, addr=0x100, wdata=0x44332211, be=0xF, mem_req rises the cycle after byte 44. byte_cnt=4.
- SET_ADDR 0x202, DATA AA, END:
  - Write addr=0x200, wdata[23:16]=AA, be=0x4.
  - done=1 after gnt.
  - in_ready=0 throughout FLUSH and DONE.
- SET_ADDR 0x0, DATA 01, SET_ADDR 0x3, DATA 02, END: single write, be=0x9, wdata=0x02000001.
- DATA 55 at 0x10, SET_ADDR 0x40, mem_gnt held low 5 cycles:
  - Flush addr=0x10 stable for 6 cycles, in_ready=0.
  - Next DATA lands at 0x40.
- SET_ADDR 0xFFFFFFFF, DATA 7E, DATA 7F:
  - First write addr=0xFFFFFFFC, be=0x8.
  - Then buffer at addr 0, be=0x1.
  - op=3 mid-stream sets err=1; a later start clears it.
- CHECKSUM_EN, DATA FF x 4, then start: csum=0x3FC, then 0; rst_n low mid-FLUSH drops mem_req immediately.

Source files
------------

// File: rtl/prog_image_pkg.sv
// Shared types and helpers for the program-image loader: command opcodes,
// FSM states and the byte-lane extraction helper.
package prog_image_pkg;

  typedef enum logic [1:0] {
    PIL_SET_ADDR = 2'd0,
    PIL_DATA     = 2'd1,
    PIL_END      = 2'd2,
    PIL_RSVD     = 2'd3
  } pil_op_e;

  typedef enum logic [1:0] {
    PIL_RUN   = 2'd0,
    PIL_FLUSH = 2'd1,
    PIL_DONE  = 2'd2
  } pil_state_e;

  // Words are at most 16 bytes wide, so the lane lives in the low address byte.
  function automatic int unsigned lane_of(input logic [7:0] addr_lo, input int unsigned bytes);
    return int'(addr_lo) & (bytes - 1);
  endfunction

endpackage

// File: rtl/prog_image_pack.sv
// Byte-lane buffer: collects bytes of one memory word with per-lane enables.
// Writes and clears never coincide; the owning FSM sequences them.
module prog_image_pack
  import prog_image_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int BYTES  = DATA_W / 8,
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [LANE_W-1:0] wr_lane_i,
  input  logic [7:0]        wr_byte_i,
  input  logic [ADDR_W-1:0] wr_word_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] buf_data_o,
  output logic [BYTES-1:0]  buf_be_o,
  output logic [ADDR_W-1:0] buf_word_o
);

  logic [BYTES-1:0][7:0] data_q;
  logic [BYTES-1:0]      be_q;
  logic [ADDR_W-1:0]     word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      be_q   <= '0;
      word_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
      be_q   <= '0;
    end else if (wr_en_i) begin
      for (int l = 0; l < BYTES; l++) begin
        if (wr_lane_i == LANE_W'(l)) begin
          data_q[l] <= wr_byte_i;
          be_q[l]   <= 1'b1;
        end
      end
      word_q <= wr_word_i;
    end
  end

  assign buf_data_o = data_q;
  assign buf_be_o   = be_q;
  assign buf_word_o = word_q;

endmodule

// File: rtl/prog_image_loader.sv
// Program-image loader: turns a SET_ADDR/DATA/END command stream into
// byte-enabled word writes. Optional running checksum: PROG_IMAGE_LOADER_CHECKSUM_EN.
module prog_image_loader
  import prog_image_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 24,
  localparam int BYTES  = DATA_W / 8,
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [ADDR_W-1:0] in_data,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BYTES-1:0]  mem_be,
  output logic              done,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic              err
`ifdef PROG_IMAGE_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       csum
`endif
);

  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32 || DATA_W == 64 || DATA_W == 128)) begin : g_bad_data_w
    $error("prog_image_loader: DATA_W must be 8, 16, 32, 64 or 128");
  end
  if (ADDR_W < 8) begin : g_bad_addr_w
    $error("prog_image_loader: ADDR_W must be at least 8");
  end

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BYTES - 1);

  pil_state_e        state_q, state_d;
  logic              end_pend_q, end_pend_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              wr_en, clr;
  logic [LANE_W-1:0] lane;
  logic [DATA_W-1:0] buf_data;
  logic [BYTES-1:0]  buf_be;
  logic [ADDR_W-1:0] buf_word;
  logic              acc;

  assign lane = LANE_W'(lane_of(cur_addr_q[7:0], BYTES));
  assign acc  = in_valid && (state_q == PIL_RUN);

  prog_image_pack #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_lane_i  (lane),
    .wr_byte_i  (in_data[7:0]),
    .wr_word_i  (cur_addr_q & WORD_MASK),
    .clr_i      (clr),
    .buf_data_o (buf_data),
    .buf_be_o   (buf_be),
    .buf_word_o (buf_word)
  );

  always_comb begin
    state_d    = state_q;
    end_pend_d = end_pend_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    clr        = 1'b0;
    unique case (state_q)
      PIL_RUN: if (acc) begin
        unique case (pil_op_e'(in_op))
          PIL_DATA: begin
            wr_en      = 1'b1;
            cur_addr_d = cur_addr_q + 1'b1;
            cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            if (lane == LANE_W'(BYTES - 1)) begin
              state_d    = PIL_FLUSH;
              end_pend_d = 1'b0;
            end
          end
          PIL_SET_ADDR: begin
            cur_addr_d = in_data;
            // Staying in the same word keeps accumulating into the open buffer.
            if ((|buf_be) && ((in_data & WORD_MASK) != buf_word)) begin
              state_d    = PIL_FLUSH;
              end_pend_d = 1'b0;
            end
          end
          PIL_END: begin
            if (|buf_be) begin
              state_d    = PIL_FLUSH;
              end_pend_d = 1'b1;
            end else begin
              state_d = PIL_DONE;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
      PIL_FLUSH: if (mem_gnt) begin
        clr     = 1'b1;
        state_d = end_pend_q ? PIL_DONE : PIL_RUN;
      end
      PIL_DONE: if (start) begin
        state_d    = PIL_RUN;
        cur_addr_d = '0;
        cnt_d      = '0;
        err_d      = 1'b0;
      end
      default: state_d = PIL_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PIL_RUN;
      end_pend_q <= 1'b0;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      end_pend_q <= end_pend_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

`ifdef PROG_IMAGE_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      csum_q <= '0;
    else if (state_q == PIL_DONE && start)
      csum_q <= '0;
    else if (acc && pil_op_e'(in_op) == PIL_DATA)
      csum_q <= csum_q + {24'd0, in_data[7:0]};
  end
  assign csum = csum_q;
`endif

  assign in_ready  = (state_q == PIL_RUN);
  assign mem_req   = (state_q == PIL_FLUSH);
  assign done      = (state_q == PIL_DONE);
  assign mem_addr  = buf_word;
  assign mem_wdata = buf_data;
  assign mem_be    = buf_be;
  assign byte_cnt  = cnt_q;
  assign err       = err_q;

endmodule
